ram_arbiter: RTL and testbench

Two-requester round-robin arbiter and fill engine in front of the `ram8x64k` single-port synchronous RAM (one read or write per cycle, read data registered one cycle after address). It multiplexes two independent request ports onto the RAM and returns read data with fixed latency. It also contains a sequencer that block-fills a contiguous address range with a constant value while requesters are stalled.

---
 rtl/ram_arbiter_if.sv | 45 ++++
 rtl/ram_arbiter.sv | 123 ++++++++++++
 tb/tb_ram_arbiter.sv | 499 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two requesters, the fill controls and the RAM port.
// slave is the arbiter side; master is the environment (requesters, fill control, RAM).
interface ram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              fill_start;
  logic [ADDR_W-1:0] fill_base;
  logic [ADDR_W:0]   fill_count;
  logic [DATA_W-1:0] fill_value;
  logic              fill_busy;
  logic              fill_done;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  fill_start, fill_base, fill_count, fill_value, ram_dout,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    output fill_busy, fill_done, ram_we, ram_addr, ram_din
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output fill_start, fill_base, fill_count, fill_value, ram_dout,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    input  fill_busy, fill_done, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM,
// with a block-fill sequencer that owns the RAM while requesters are stalled.
module ram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  ram_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t            state_reg;
  logic              last_reg;
  logic [ADDR_W-1:0] cur_addr_reg;
  logic [ADDR_W:0]   remaining_reg;
  logic [DATA_W-1:0] value_reg;
  logic [ADDR_W-1:0] addr_hold_reg;
  logic [DATA_W-1:0] din_hold_reg;
  logic              rvalid0_reg;
  logic              rvalid1_reg;
  logic              fill_done_reg;

  logic              gnt0;
  logic              gnt1;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;

  // On a tie the port that was not served last wins; with no grant the RAM
  // address/data keep their previous values so idle reads are harmless.
  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    ram_we   = 1'b0;
    ram_addr = addr_hold_reg;
    ram_din  = din_hold_reg;
    if (!rst && state_reg == IDLE) begin
      gnt0 = bus.req0 & (~bus.req1 | last_reg);
      gnt1 = bus.req1 & (~bus.req0 | ~last_reg);
      if (gnt0) begin
        ram_we   = bus.we0;
        ram_addr = bus.addr0;
        ram_din  = bus.wdata0;
      end else if (gnt1) begin
        ram_we   = bus.we1;
        ram_addr = bus.addr1;
        ram_din  = bus.wdata1;
      end
    end else if (!rst && state_reg == FILL) begin
      ram_we   = 1'b1;
      ram_addr = cur_addr_reg;
      ram_din  = value_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      last_reg      <= 1'b1;
      cur_addr_reg  <= '0;
      remaining_reg <= '0;
      value_reg     <= '0;
      addr_hold_reg <= '0;
      din_hold_reg  <= '0;
      rvalid0_reg   <= 1'b0;
      rvalid1_reg   <= 1'b0;
      fill_done_reg <= 1'b0;
    end else begin
      addr_hold_reg <= ram_addr;
      din_hold_reg  <= ram_din;
      rvalid0_reg   <= gnt0 & ~bus.we0;
      rvalid1_reg   <= gnt1 & ~bus.we1;
      fill_done_reg <= 1'b0;
      if (gnt0) begin
        last_reg <= 1'b0;
      end else if (gnt1) begin
        last_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (bus.fill_start) begin
            // An empty fill completes immediately without ever touching the RAM.
            if (bus.fill_count == '0) begin
              fill_done_reg <= 1'b1;
            end else begin
              state_reg     <= FILL;
              cur_addr_reg  <= bus.fill_base;
              remaining_reg <= bus.fill_count;
              value_reg     <= bus.fill_value;
            end
          end
        end
        FILL: begin
          cur_addr_reg  <= cur_addr_reg + ADDR_W'(1);
          remaining_reg <= remaining_reg - {{ADDR_W{1'b0}}, 1'b1};
          if (remaining_reg == {{ADDR_W{1'b0}}, 1'b1}) begin
            state_reg     <= IDLE;
            fill_done_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.rvalid0   = rvalid0_reg;
  assign bus.rvalid1   = rvalid1_reg;
  assign bus.rdata0    = bus.ram_dout;
  assign bus.rdata1    = bus.ram_dout;
  assign bus.fill_busy = (state_reg == FILL);
  assign bus.fill_done = fill_done_reg;
  assign bus.ram_we    = ram_we;
  assign bus.ram_addr  = ram_addr;
  assign bus.ram_din   = ram_din;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a behavioural 64Kx8 RAM plus a reference memory image
// and last-served pointer derived from the arbitration and fill rules.
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  ram_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous RAM with one-cycle registered read.
  logic [7:0] mem [0:65535];
  logic [7:0] ram_q;
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    ram_q <= mem[bus.ram_addr];
  end
  assign bus.ram_dout = ram_q;

  int unsigned wr_count = 0;
  logic [15:0] last_wr_addr;
  always @(posedge clk) begin
    if (bus.ram_we === 1'b1) begin
      wr_count++;
      last_wr_addr = bus.ram_addr;
    end
  end

  int tests = 0;
  int fails = 0;
  logic [7:0] ref_mem   [0:65535];
  bit         ref_valid [0:65535];
  int         ref_last;

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    bus.fill_start = 0; bus.fill_base = '0; bus.fill_count = '0; bus.fill_value = '0;
  endtask

  task automatic do_read(input int port, input logic [15:0] a, output logic [7:0] d, output bit ok);
    bit got;
    got = 0; ok = 0; d = '0;
    if (port == 0) begin bus.req0 = 1; bus.we0 = 0; bus.addr0 = a; end
    else begin bus.req1 = 1; bus.we1 = 0; bus.addr1 = a; end
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk);
      got = (port == 0) ? bus.gnt0 : bus.gnt1;
      next_cycle;
    end
    bus.req0 = 0; bus.req1 = 0;
    if (got) begin
      ref_last = port;
      @(negedge clk);
      ok = (port == 0) ? bus.rvalid0 : bus.rvalid1;
      d  = (port == 0) ? bus.rdata0 : bus.rdata1;
      next_cycle;
    end
  endtask

  task automatic do_write(input int port, input logic [15:0] a, input logic [7:0] d, output bit ok);
    bit got;
    got = 0;
    if (port == 0) begin bus.req0 = 1; bus.we0 = 1; bus.addr0 = a; bus.wdata0 = d; end
    else begin bus.req1 = 1; bus.we1 = 1; bus.addr1 = a; bus.wdata1 = d; end
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk);
      got = (port == 0) ? bus.gnt0 : bus.gnt1;
      next_cycle;
    end
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    if (got) begin
      ref_last = port;
      ref_mem[a] = d;
      ref_valid[a] = 1;
    end
    ok = got;
  endtask

  task automatic test_reset;
    idle_inputs;
    rst = 1;
    bus.req0 = 1; bus.req1 = 1; bus.we0 = 1; bus.addr0 = 16'h00FF; bus.wdata0 = 8'hEE;
    bus.fill_start = 1; bus.fill_count = 17'd5;
    @(negedge clk);
    tests++;
    if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.fill_busy, bus.fill_done, bus.ram_we} !== 7'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got gnt%b%b rv%b%b busy%b done%b we%b, expected all 0",
               bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.fill_busy, bus.fill_done, bus.ram_we);
    end
    tests++;
    if ({bus.ram_addr, bus.ram_din} !== 24'h0) begin
      fails++;
      $display("FAIL reset_bus: got addr %h din %h, expected 0000 00", bus.ram_addr, bus.ram_din);
    end
    idle_inputs;
    next_cycle;
    rst = 0;
    ref_last = 1;
    @(negedge clk);
    tests++;
    if ({bus.fill_busy, bus.fill_done} !== 2'b00) begin
      fails++;
      $display("FAIL reset_release: got busy %b done %b, expected 0 0", bus.fill_busy, bus.fill_done);
    end
    next_cycle;
  endtask

  task automatic test_single_port;
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 16'h1234; bus.wdata0 = 8'hA5;
    @(negedge clk);
    tests++;
    if ({bus.gnt0, bus.gnt1, bus.ram_we, bus.ram_addr, bus.ram_din} !== {3'b101, 16'h1234, 8'hA5}) begin
      fails++;
      $display("FAIL single_write: got gnt%b%b we%b addr %h din %h, expected gnt10 we1 addr 1234 din a5",
               bus.gnt0, bus.gnt1, bus.ram_we, bus.ram_addr, bus.ram_din);
    end
    next_cycle;
    ref_mem[16'h1234] = 8'hA5; ref_valid[16'h1234] = 1;
    bus.we0 = 0;
    @(negedge clk);
    tests++;
    if ({bus.gnt0, bus.gnt1, bus.ram_we, bus.rvalid0} !== 4'b1000) begin
      fails++;
      $display("FAIL single_read_gnt: got gnt%b%b we%b rv0 %b, expected gnt10 we0 rv0 0",
               bus.gnt0, bus.gnt1, bus.ram_we, bus.rvalid0);
    end
    next_cycle;
    bus.req0 = 0;
    @(negedge clk);
    tests++;
    if ({bus.rvalid0, bus.rvalid1, bus.rdata0} !== {2'b10, 8'hA5}) begin
      fails++;
      $display("FAIL single_read_data: got rv%b%b rdata0 %h, expected rv10 rdata0 a5",
               bus.rvalid0, bus.rvalid1, bus.rdata0);
    end
    next_cycle;
    ref_last = 0;
  endtask

  task automatic test_contention;
    logic [15:0] a [2];
    logic [7:0]  exp_rd;
    bit          exp_kn;
    int          prev_w;
    rst = 1; idle_inputs; next_cycle; next_cycle; rst = 0; ref_last = 1;
    a[0] = 16'h4000 + 16'($urandom_range(0, 15));
    a[1] = 16'h4000 + 16'($urandom_range(0, 15));
    prev_w = -1; exp_rd = '0; exp_kn = 0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = a[0];
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = a[1];
      end else begin
        idle_inputs;
      end
      @(negedge clk);
      if (i < 4) begin
        tests++;
        if ({bus.gnt0, bus.gnt1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
          fails++;
          $display("FAIL contention_gnt #%0d: got gnt%b%b, expected port %0d", i, bus.gnt0, bus.gnt1, i % 2);
        end
      end
      tests++;
      if ({bus.rvalid0, bus.rvalid1} !== ((prev_w < 0) ? 2'b00 : (prev_w == 0) ? 2'b10 : 2'b01)) begin
        fails++;
        $display("FAIL contention_rvalid #%0d: got rv%b%b, expected from port %0d", i, bus.rvalid0, bus.rvalid1, prev_w);
      end
      if (prev_w >= 0 && exp_kn) begin
        tests++;
        if (((prev_w == 0) ? bus.rdata0 : bus.rdata1) !== exp_rd) begin
          fails++;
          $display("FAIL contention_rdata #%0d: got %h, expected %h", i, (prev_w == 0) ? bus.rdata0 : bus.rdata1, exp_rd);
        end
      end
      if (i < 4) begin
        prev_w = i % 2;
        exp_rd = ref_mem[a[prev_w]];
        exp_kn = ref_valid[a[prev_w]];
        a[prev_w] = 16'h4000 + 16'($urandom_range(0, 15));
      end
      next_cycle;
    end
    ref_last = 1;
  endtask

  task automatic test_random(input int n);
    bit          p_act [2];
    logic        p_we  [2];
    logic [15:0] p_addr[2];
    logic [7:0]  p_wd  [2];
    bit          exp_rv[2];
    bit          exp_kn[2];
    logic [7:0]  exp_rd[2];
    int          w;
    for (int k = 0; k < 2; k++) begin
      p_act[k] = 0; p_we[k] = 0; p_addr[k] = '0; p_wd[k] = '0;
      exp_rv[k] = 0; exp_kn[k] = 0; exp_rd[k] = '0;
    end
    for (int i = 0; i <= n; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (!p_act[k] && i < n && $urandom_range(0, 9) < 6) begin
          p_act[k]  = 1;
          p_we[k]   = 1'($urandom_range(0, 1));
          p_addr[k] = 16'h4000 + 16'($urandom_range(0, 15));
          p_wd[k]   = 8'($urandom);
        end
      end
      if (i == n) begin p_act[0] = 0; p_act[1] = 0; end
      bus.req0 = p_act[0]; bus.we0 = p_we[0]; bus.addr0 = p_addr[0]; bus.wdata0 = p_wd[0];
      bus.req1 = p_act[1]; bus.we1 = p_we[1]; bus.addr1 = p_addr[1]; bus.wdata1 = p_wd[1];
      @(negedge clk);
      if (p_act[0] && p_act[1]) w = (ref_last == 0) ? 1 : 0;
      else if (p_act[0])        w = 0;
      else if (p_act[1])        w = 1;
      else                      w = -1;
      tests++;
      if ({bus.gnt0, bus.gnt1} !== {w == 0, w == 1}) begin
        fails++;
        $display("FAIL random_gnt cycle %0d: got gnt%b%b, expected winner %0d", i, bus.gnt0, bus.gnt1, w);
      end
      tests++;
      if ({bus.rvalid0, bus.rvalid1} !== {exp_rv[0], exp_rv[1]}) begin
        fails++;
        $display("FAIL random_rvalid cycle %0d: got rv%b%b, expected rv%b%b", i, bus.rvalid0, bus.rvalid1, exp_rv[0], exp_rv[1]);
      end
      for (int k = 0; k < 2; k++) begin
        if (exp_rv[k] && exp_kn[k]) begin
          tests++;
          if (((k == 0) ? bus.rdata0 : bus.rdata1) !== exp_rd[k]) begin
            fails++;
            $display("FAIL random_rdata%0d cycle %0d: got %h, expected %h", k, i, (k == 0) ? bus.rdata0 : bus.rdata1, exp_rd[k]);
          end
        end
      end
      tests++;
      if (bus.ram_we !== ((w >= 0) ? p_we[w] : 1'b0)) begin
        fails++;
        $display("FAIL random_we cycle %0d: got %b, expected %b", i, bus.ram_we, (w >= 0) ? p_we[w] : 1'b0);
      end
      if (w >= 0) begin
        tests++;
        if (bus.ram_addr !== p_addr[w]) begin
          fails++;
          $display("FAIL random_addr cycle %0d: got %h, expected %h", i, bus.ram_addr, p_addr[w]);
        end
      end
      exp_rv[0] = 0; exp_rv[1] = 0;
      if (w >= 0) begin
        if (p_we[w]) begin
          ref_mem[p_addr[w]] = p_wd[w];
          ref_valid[p_addr[w]] = 1;
        end else begin
          exp_rv[w] = 1;
          exp_rd[w] = ref_mem[p_addr[w]];
          exp_kn[w] = ref_valid[p_addr[w]];
        end
        ref_last = w;
        p_act[w] = 0;
      end
      next_cycle;
    end
    idle_inputs;
  endtask

  task automatic test_fill_wrap;
    bit          ok;
    int unsigned wr0;
    logic [15:0] ea;
    logic [7:0]  d;
    logic [15:0] rb_a [5];
    logic [7:0]  rb_e [5];
    do_write(1, 16'h0002, 8'h3C, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL fill_wrap_prewrite: got no grant, expected grant"); end
    wr0 = wr_count;
    bus.fill_start = 1; bus.fill_base = 16'hFFFE; bus.fill_count = 17'd4; bus.fill_value = 8'h55;
    @(negedge clk);
    tests++;
    if (bus.fill_busy !== 1'b0) begin fails++; $display("FAIL fill_wrap_start_busy: got %b, expected 0", bus.fill_busy); end
    next_cycle;
    bus.fill_start = 0;
    for (int k = 0; k < 4; k++) begin
      ea = 16'hFFFE + 16'(k);
      @(negedge clk);
      tests++;
      if ({bus.fill_busy, bus.ram_we, bus.fill_done, bus.ram_addr, bus.ram_din} !== {3'b110, ea, 8'h55}) begin
        fails++;
        $display("FAIL fill_wrap_write%0d: got busy%b we%b done%b addr %h din %h, expected busy1 we1 done0 addr %h din 55",
                 k, bus.fill_busy, bus.ram_we, bus.fill_done, bus.ram_addr, bus.ram_din, ea);
      end
      next_cycle;
    end
    @(negedge clk);
    tests++;
    if ({bus.fill_busy, bus.fill_done} !== 2'b01) begin
      fails++;
      $display("FAIL fill_wrap_done: got busy %b done %b, expected 0 1", bus.fill_busy, bus.fill_done);
    end
    next_cycle;
    @(negedge clk);
    tests++;
    if (bus.fill_done !== 1'b0) begin fails++; $display("FAIL fill_wrap_done_pulse: got %b, expected 0", bus.fill_done); end
    next_cycle;
    tests++;
    if (wr_count - wr0 !== 32'd4) begin fails++; $display("FAIL fill_wrap_count: got %0d writes, expected 4", wr_count - wr0); end
    rb_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002};
    rb_e = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h3C};
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin ref_mem[rb_a[k]] = 8'h55; ref_valid[rb_a[k]] = 1; end
      do_read(0, rb_a[k], d, ok);
      tests++;
      if (!ok || d !== rb_e[k]) begin
        fails++;
        $display("FAIL fill_wrap_readback %h: got valid %b data %h, expected valid 1 data %h", rb_a[k], ok, d, rb_e[k]);
      end
    end
  endtask

  task automatic test_fill_vs_req;
    int unsigned wr0;
    idle_inputs;
    wr0 = wr_count;
    bus.fill_start = 1; bus.fill_base = 16'h5000; bus.fill_count = 17'd8; bus.fill_value = 8'h77;
    next_cycle;
    bus.fill_start = 0;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 16'h5003;
    for (int k = 1; k <= 8; k++) begin
      if (k == 3) begin
        bus.fill_start = 1; bus.fill_base = 16'h6000; bus.fill_count = 17'd3; bus.fill_value = 8'h11;
      end else begin
        bus.fill_start = 0;
      end
      @(negedge clk);
      tests++;
      if ({bus.gnt1, bus.fill_busy, bus.ram_addr} !== {2'b01, 16'h5000 + 16'(k - 1)}) begin
        fails++;
        $display("FAIL fill_req_stall cycle %0d: got gnt1 %b busy %b addr %h, expected gnt1 0 busy 1 addr %h",
                 k, bus.gnt1, bus.fill_busy, bus.ram_addr, 16'h5000 + 16'(k - 1));
      end
      next_cycle;
    end
    bus.fill_start = 0;
    for (int k = 0; k < 8; k++) begin ref_mem[16'h5000 + 16'(k)] = 8'h77; ref_valid[16'h5000 + 16'(k)] = 1; end
    @(negedge clk);
    tests++;
    if ({bus.gnt1, bus.fill_done, bus.fill_busy} !== 3'b110) begin
      fails++;
      $display("FAIL fill_req_resume: got gnt1 %b done %b busy %b, expected 1 1 0", bus.gnt1, bus.fill_done, bus.fill_busy);
    end
    next_cycle;
    ref_last = 1;
    bus.req1 = 0;
    @(negedge clk);
    tests++;
    if ({bus.rvalid1, bus.rdata1} !== {1'b1, 8'h77}) begin
      fails++;
      $display("FAIL fill_req_rdata: got rv1 %b data %h, expected 1 77", bus.rvalid1, bus.rdata1);
    end
    repeat (5) next_cycle;
    tests++;
    if (wr_count - wr0 !== 32'd8) begin fails++; $display("FAIL fill_req_count: got %0d writes, expected 8", wr_count - wr0); end
  endtask

  task automatic test_edge_counts;
    int unsigned wr0;
    int          cyc;
    logic [15:0] base;
    idle_inputs;
    wr0 = wr_count;
    bus.fill_start = 1; bus.fill_base = 16'h7000; bus.fill_count = '0; bus.fill_value = 8'h99;
    next_cycle;
    bus.fill_start = 0;
    @(negedge clk);
    tests++;
    if ({bus.fill_done, bus.ram_we} !== 2'b10) begin
      fails++;
      $display("FAIL fill_zero_done: got done %b we %b, expected 1 0", bus.fill_done, bus.ram_we);
    end
    next_cycle;
    @(negedge clk);
    tests++;
    if ({bus.fill_done, bus.ram_we, wr_count - wr0} !== {2'b00, 32'd0}) begin
      fails++;
      $display("FAIL fill_zero_after: got done %b we %b writes %0d, expected 0 0 0", bus.fill_done, bus.ram_we, wr_count - wr0);
    end
    next_cycle;

    base = 16'($urandom);
    wr0 = wr_count;
    bus.fill_start = 1; bus.fill_base = base; bus.fill_count = 17'h10000; bus.fill_value = 8'hC3;
    next_cycle;
    bus.fill_start = 0;
    for (cyc = 1; cyc <= 65600; cyc++) begin
      @(negedge clk);
      if (bus.fill_done) break;
      next_cycle;
    end
    next_cycle;
    tests++;
    if (cyc !== 65537) begin fails++; $display("FAIL fill_full_done_time: got cycle %0d, expected 65537", cyc); end
    tests++;
    if (wr_count - wr0 !== 32'd65536) begin fails++; $display("FAIL fill_full_count: got %0d writes, expected 65536", wr_count - wr0); end
    tests++;
    if (last_wr_addr !== base - 16'd1) begin
      fails++;
      $display("FAIL fill_full_last_addr: got %h, expected %h", last_wr_addr, base - 16'd1);
    end
    for (int i = 0; i < 65536; i++) begin ref_mem[i] = 8'hC3; ref_valid[i] = 1; end
  endtask

  task automatic test_reset_midfill;
    bit         ok;
    logic [7:0] d;
    idle_inputs;
    bus.fill_start = 1; bus.fill_base = 16'h8000; bus.fill_count = 17'd10; bus.fill_value = 8'h2D;
    next_cycle;
    bus.fill_start = 0;
    next_cycle;
    next_cycle;
    rst = 1;
    @(negedge clk);
    tests++;
    if ({bus.fill_busy, bus.ram_we, bus.fill_done} !== 3'b000) begin
      fails++;
      $display("FAIL midfill_reset: got busy %b we %b done %b, expected 0 0 0", bus.fill_busy, bus.ram_we, bus.fill_done);
    end
    next_cycle;
    rst = 0;
    ref_last = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if ({bus.fill_busy, bus.fill_done, bus.ram_we} !== 3'b000) begin
        fails++;
        $display("FAIL midfill_quiet cycle %0d: got busy %b done %b we %b, expected 0 0 0", k, bus.fill_busy, bus.fill_done, bus.ram_we);
      end
      next_cycle;
    end
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h8000;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 16'h8005;
    @(negedge clk);
    tests++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      fails++;
      $display("FAIL midfill_tie: got gnt%b%b, expected gnt10", bus.gnt0, bus.gnt1);
    end
    next_cycle;
    idle_inputs;
    ref_last = 0;
    next_cycle;
    ref_mem[16'h8000] = 8'h2D;
    ref_mem[16'h8001] = 8'h2D;
    for (int k = 0; k < 10; k++) begin
      do_read(0, 16'h8000 + 16'(k), d, ok);
      tests++;
      if (!ok || d !== ((k < 2) ? 8'h2D : 8'hC3)) begin
        fails++;
        $display("FAIL midfill_word%0d: got valid %b data %h, expected valid 1 data %h", k, ok, d, (k < 2) ? 8'h2D : 8'hC3);
      end
    end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) ref_valid[i] = 0;
    ref_last = 1;
    test_reset;
    test_single_port;
    test_contention;
    test_random(300);
    test_fill_wrap;
    test_fill_vs_req;
    test_edge_counts;
    test_reset_midfill;
    test_random(200);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
